// File: rtl/v810_tagstore.sv
// v810_tagstore: 2-way set-associative tag store with per-set LRU bit.
// Tags, valid bits and LRU bits live in flops and are read asynchronously.
// A whole-array invalidate (from reset or inv_all) walks one set per cycle.
// While that walk runs, lookups miss and all writes are ignored.
module v810_tagstore #(
  parameter int index_width = 7,
  parameter int tag_width   = 22
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [index_width-1:0] lu_index,
  input  logic [tag_width-1:0]   lu_tag,
  input  logic                   lu_en,
  output logic                   lu_hit,
  output logic                   lu_way,
  input  logic                   fill_en,
  input  logic [index_width-1:0] fill_index,
  input  logic [tag_width-1:0]   fill_tag,
  output logic                   fill_way,
  input  logic                   inv_line_en,
  input  logic [index_width-1:0] inv_index,
  input  logic                   inv_all,
  output logic                   busy
);

  localparam int NumSets = 1 << index_width;

  typedef enum logic {
    IDLE  = 1'b0,
    SWEEP = 1'b1
  } state_t;

  state_t                 r_state;
  state_t                 w_stateNext;
  logic [index_width-1:0] r_count;
  logic [index_width-1:0] w_countNext;
  logic                   w_sweepClr;

  // Tag arrays carry no reset: a tag is only meaningful when its valid bit is set.
  logic [tag_width-1:0]   r_tag0 [NumSets];
  logic [tag_width-1:0]   r_tag1 [NumSets];
  logic [NumSets-1:0]     r_valid0;
  logic [NumSets-1:0]     r_valid1;
  logic [NumSets-1:0]     r_lru;

  logic                   w_luMatch0;
  logic                   w_luMatch1;
  logic                   w_fillMatch0;
  logic                   w_fillMatch1;
  logic                   w_writeOk;
  logic                   w_invDo;
  logic                   w_fillDo;
  logic                   w_lruDo;

  assign busy = (r_state == SWEEP);

  // Compare the lookup tag against both ways of the addressed set.
  always_comb begin
    w_luMatch0 = r_valid0[lu_index] && (r_tag0[lu_index] == lu_tag);
    w_luMatch1 = r_valid1[lu_index] && (r_tag1[lu_index] == lu_tag);
  end

  // A hit is suppressed during a sweep; way 0 wins if both ways somehow match.
  always_comb begin
    lu_hit = !busy && (w_luMatch0 || w_luMatch1);
    lu_way = lu_hit && !w_luMatch0;
  end

  // Victim choice: reuse a matching way, else the first empty way, else LRU.
  always_comb begin
    w_fillMatch0 = r_valid0[fill_index] && (r_tag0[fill_index] == fill_tag);
    w_fillMatch1 = r_valid1[fill_index] && (r_tag1[fill_index] == fill_tag);
    fill_way     = r_lru[fill_index];
    if (w_fillMatch0) begin
      fill_way = 1'b0;
    end else if (w_fillMatch1) begin
      fill_way = 1'b1;
    end else if (!r_valid0[fill_index]) begin
      fill_way = 1'b0;
    end else if (!r_valid1[fill_index]) begin
      fill_way = 1'b1;
    end
  end

  // Write qualification: a starting sweep or reset wins over everything, then
  // line invalidate, then fill, then the lookup LRU touch on a distinct set.
  always_comb begin
    w_writeOk = !busy && !inv_all && !reset;
    w_invDo   = w_writeOk && inv_line_en;
    w_fillDo  = w_writeOk && fill_en &&
                !(inv_line_en && (fill_index == inv_index));
    w_lruDo   = w_writeOk && lu_en && lu_hit &&
                !(inv_line_en && (lu_index == inv_index)) &&
                !(fill_en && (lu_index == fill_index));
  end

  // Sweep sequencing: start from IDLE on inv_all, restart on inv_all, stop after the last set.
  always_comb begin
    w_stateNext = r_state;
    w_countNext = r_count;
    w_sweepClr  = 1'b0;
    case (r_state)
      IDLE: begin
        if (inv_all) begin
          w_stateNext = SWEEP;
          w_countNext = '0;
        end
      end
      SWEEP: begin
        w_sweepClr = 1'b1;
        if (inv_all) begin
          w_countNext = '0;
        end else if (r_count == '1) begin
          w_stateNext = IDLE;
          w_countNext = '0;
        end else begin
          w_countNext = r_count + 1'b1;
        end
      end
      default: begin
        w_stateNext = SWEEP;
        w_countNext = '0;
      end
    endcase
  end

  // State register; reset always (re)starts a sweep from set 0.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= SWEEP;
      r_count <= '0;
    end else begin
      r_state <= w_stateNext;
      r_count <= w_countNext;
    end
  end

  // Valid and LRU updates; only the sweep ever clears the whole array.
  always_ff @(posedge clock) begin
    if (!reset) begin
      if (w_sweepClr) begin
        r_valid0[r_count] <= 1'b0;
        r_valid1[r_count] <= 1'b0;
        r_lru[r_count]    <= 1'b0;
      end
      if (w_invDo) begin
        r_valid0[inv_index] <= 1'b0;
        r_valid1[inv_index] <= 1'b0;
        r_lru[inv_index]    <= 1'b0;
      end
      if (w_fillDo) begin
        if (fill_way) begin
          r_valid1[fill_index] <= 1'b1;
        end else begin
          r_valid0[fill_index] <= 1'b1;
        end
        r_lru[fill_index] <= ~fill_way;
      end
      if (w_lruDo) begin
        r_lru[lu_index] <= ~lu_way;
      end
    end
  end

  // Tag write for an accepted fill into the chosen way.
  always_ff @(posedge clock) begin
    if (w_fillDo) begin
      if (fill_way) begin
        r_tag1[fill_index] <= fill_tag;
      end else begin
        r_tag0[fill_index] <= fill_tag;
      end
    end
  end

endmodule

// File: tb/tb_v810_tagstore.sv
// tb_v810_tagstore: directed scenarios followed by random traffic, all checked
// against a per-set reference model of the 2-way tag store.
module tb_v810_tagstore;

  localparam int IW = 2;
  localparam int TW = 8;
  localparam int NS = 4;

  logic          clock = 1'b0;
  logic          reset;
  logic [IW-1:0] luIndex;
  logic [TW-1:0] luTag;
  logic          luEn;
  logic          luHit;
  logic          luWay;
  logic          fillEn;
  logic [IW-1:0] fillIndex;
  logic [TW-1:0] fillTag;
  logic          fillWay;
  logic          invLineEn;
  logic [IW-1:0] invIndex;
  logic          invAll;
  logic          busy;

  typedef struct packed {
    logic          rst;
    logic          luEn;
    logic [IW-1:0] luIndex;
    logic [TW-1:0] luTag;
    logic          fillEn;
    logic [IW-1:0] fillIndex;
    logic [TW-1:0] fillTag;
    logic          invLineEn;
    logic [IW-1:0] invIndex;
    logic          invAll;
  } stim_t;

  stim_t s;
  int    nVectors = 0;
  int    nMiscompares = 0;
  logic  obsHit, obsWay, obsFillWay, obsBusy;

  // Reference model state
  logic [TW-1:0] mTag [NS][2];
  bit            mValid [NS][2];
  bit            mLru [NS];
  bit            mSweep = 1'b0;
  int            mPos = 0;
  bit            mInit = 1'b0;

  v810_tagstore #(.index_width(IW), .tag_width(TW)) dut (
    .clock(clock), .reset(reset),
    .lu_index(luIndex), .lu_tag(luTag), .lu_en(luEn),
    .lu_hit(luHit), .lu_way(luWay),
    .fill_en(fillEn), .fill_index(fillIndex), .fill_tag(fillTag),
    .fill_way(fillWay),
    .inv_line_en(invLineEn), .inv_index(invIndex),
    .inv_all(invAll), .busy(busy)
  );

  always #5 clock = ~clock;

  function automatic void modelLookup(input int idx, input logic [TW-1:0] tag,
                                      output bit hit, output bit way);
    bit h0, h1;
    h0  = mValid[idx][0] && (mTag[idx][0] == tag);
    h1  = mValid[idx][1] && (mTag[idx][1] == tag);
    hit = !mSweep && (h0 || h1);
    way = hit ? !h0 : 1'b0;
  endfunction

  function automatic bit modelFillWay(input int idx, input logic [TW-1:0] tag);
    if (mValid[idx][0] && mTag[idx][0] == tag) return 1'b0;
    if (mValid[idx][1] && mTag[idx][1] == tag) return 1'b1;
    if (!mValid[idx][0]) return 1'b0;
    if (!mValid[idx][1]) return 1'b1;
    return mLru[idx];
  endfunction

  function automatic void modelClearSet(input int idx);
    mValid[idx][0] = 1'b0;
    mValid[idx][1] = 1'b0;
    mLru[idx]      = 1'b0;
  endfunction

  task automatic modelEdge();
    bit fw, h, w;
    if (s.rst) begin
      mSweep = 1'b1;
      mPos   = 0;
      mInit  = 1'b1;
      return;
    end
    if (!mInit) return;
    if (mSweep) begin
      modelClearSet(mPos);
      if (s.invAll) mPos = 0;
      else if (mPos == NS - 1) mSweep = 1'b0;
      else mPos++;
      return;
    end
    if (s.invAll) begin
      mSweep = 1'b1;
      mPos   = 0;
      return;
    end
    fw = modelFillWay(int'(s.fillIndex), s.fillTag);
    modelLookup(int'(s.luIndex), s.luTag, h, w);
    if (s.invLineEn) modelClearSet(int'(s.invIndex));
    if (s.fillEn && !(s.invLineEn && s.fillIndex == s.invIndex)) begin
      mTag[s.fillIndex][fw]   = s.fillTag;
      mValid[s.fillIndex][fw] = 1'b1;
      mLru[s.fillIndex]       = !fw;
    end
    if (s.luEn && h && !(s.invLineEn && s.luIndex == s.invIndex) &&
        !(s.fillEn && s.luIndex == s.fillIndex))
      mLru[s.luIndex] = !w;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    nVectors++;
    assert (observed === expected) else begin
      nMiscompares++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  // Drive s at the falling edge, check outputs, then let one rising edge pass.
  task automatic applyStimulus();
    bit eHit, eWay;
    @(negedge clock);
    reset     = s.rst;
    luEn      = s.luEn;
    luIndex   = s.luIndex;
    luTag     = s.luTag;
    fillEn    = s.fillEn;
    fillIndex = s.fillIndex;
    fillTag   = s.fillTag;
    invLineEn = s.invLineEn;
    invIndex  = s.invIndex;
    invAll    = s.invAll;
    #1;
    obsHit     = luHit;
    obsWay     = luWay;
    obsFillWay = fillWay;
    obsBusy    = busy;
    if (mInit) begin
      modelLookup(int'(s.luIndex), s.luTag, eHit, eWay);
      checkOutput("lu_hit", luHit, eHit);
      checkOutput("lu_way", luWay, eWay);
      checkOutput("fill_way", fillWay, modelFillWay(int'(s.fillIndex), s.fillTag));
      checkOutput("busy", busy, mSweep);
    end
    @(posedge clock);
    modelEdge();
  endtask

  task automatic doFill(input int idx, input logic [TW-1:0] tag);
    s = '0;
    s.fillEn    = 1'b1;
    s.fillIndex = IW'(idx);
    s.fillTag   = tag;
    applyStimulus();
  endtask

  task automatic doLookup(input int idx, input logic [TW-1:0] tag, input bit en);
    s = '0;
    s.luEn    = en;
    s.luIndex = IW'(idx);
    s.luTag   = tag;
    applyStimulus();
  endtask

  initial begin
    int n;
    reset = 1'b0; luEn = 1'b0; luIndex = '0; luTag = '0;
    fillEn = 1'b0; fillIndex = '0; fillTag = '0;
    invLineEn = 1'b0; invIndex = '0; invAll = 1'b0;
    for (int i = 0; i < NS; i++) begin
      mTag[i][0] = '0; mTag[i][1] = '0;
      mValid[i][0] = 1'b0; mValid[i][1] = 1'b0; mLru[i] = 1'b0;
    end

    // Reset held for two edges, then count busy cycles after release
    s = '0; s.rst = 1'b1;
    applyStimulus();
    applyStimulus();
    n = 0;
    for (int i = 0; i < 20; i++) begin
      s = '0;
      s.luIndex = IW'($urandom_range(0, NS - 1));
      s.luTag   = TW'($urandom);
      applyStimulus();
      if (!obsBusy) break;
      n++;
    end
    checkOutput("busyCyclesAfterReset", n, 4);
    doLookup($urandom_range(0, NS - 1), TW'($urandom), 1'b1);
    checkOutput("hitAfterReset", obsHit, 0);

    // Two fills into set 1 occupy way 0 then way 1
    doFill(1, 8'h11);
    doFill(1, 8'h22);
    doLookup(1, 8'h22, 1'b0);
    checkOutput("hit_1_22", obsHit, 1);
    checkOutput("way_1_22", obsWay, 1);
    doLookup(1, 8'h11, 1'b0);
    checkOutput("way_1_11", obsWay, 0);
    doLookup(1, 8'h33, 1'b0);
    checkOutput("hit_1_33", obsHit, 0);

    // Touching 0x11 makes 0x22 the victim
    doLookup(1, 8'h11, 1'b1);
    doFill(1, 8'h33);
    checkOutput("fillway_1_33", obsFillWay, 1);
    doLookup(1, 8'h22, 1'b0);
    checkOutput("evicted_1_22", obsHit, 0);
    doLookup(1, 8'h11, 1'b0);
    checkOutput("hit_1_11", obsHit, 1);
    doLookup(1, 8'h33, 1'b0);
    checkOutput("hit_1_33b", obsHit, 1);
    checkOutput("way_1_33", obsWay, 1);

    // Refill of a resident tag reuses its way
    doFill(2, 8'h44);
    doFill(2, 8'h44);
    checkOutput("refill_way_2_44", obsFillWay, 0);
    s = '0; s.fillIndex = 2'd2; s.fillTag = 8'h55;
    applyStimulus();
    checkOutput("fillway_2_new", obsFillWay, 1);
    doLookup(2, 8'h44, 1'b0);
    checkOutput("way_2_44", obsWay, 0);

    // inv_all, restarted on the second busy cycle, with a fill held throughout
    s = '0; s.invAll = 1'b1;
    applyStimulus();
    n = 0;
    for (int i = 0; i < 30; i++) begin
      s = '0;
      s.fillEn = 1'b1; s.fillIndex = 2'd0; s.fillTag = 8'h99;
      s.luIndex = 2'd0; s.luTag = 8'h99;
      s.invAll = (n == 1);
      applyStimulus();
      if (!obsBusy) break;
      n++;
    end
    checkOutput("busyCyclesRestart", n, 6);
    checkOutput("noFillDuringSweep", obsHit, 0);
    doLookup(1, 8'h11, 1'b0);
    checkOutput("swept_1_11", obsHit, 0);
    doLookup(1, 8'h33, 1'b0);
    checkOutput("swept_1_33", obsHit, 0);
    doLookup(2, 8'h44, 1'b0);
    checkOutput("swept_2_44", obsHit, 0);

    // Line invalidate beats a same-set fill but not a different-set fill
    doFill(3, 8'h5A);
    doLookup(3, 8'h5A, 1'b0);
    checkOutput("hit_3_5A", obsHit, 1);
    s = '0; s.invLineEn = 1'b1; s.invIndex = 2'd3;
    s.fillEn = 1'b1; s.fillIndex = 2'd3; s.fillTag = 8'h66;
    applyStimulus();
    doLookup(3, 8'h66, 1'b0);
    checkOutput("dropped_3_66", obsHit, 0);
    doLookup(3, 8'h5A, 1'b0);
    checkOutput("inv_3_5A", obsHit, 0);
    s = '0; s.invLineEn = 1'b1; s.invIndex = 2'd3;
    s.fillEn = 1'b1; s.fillIndex = 2'd0; s.fillTag = 8'h77;
    applyStimulus();
    doLookup(0, 8'h77, 1'b0);
    checkOutput("landed_0_77", obsHit, 1);

    // Random traffic on a small tag range so hits and evictions are frequent
    for (int i = 0; i < 400; i++) begin
      int r;
      r = $urandom_range(0, 199);
      s = '0;
      s.rst       = (r == 0);
      s.invAll    = (r >= 1 && r <= 3);
      s.luEn      = 1'($urandom_range(0, 1));
      s.luIndex   = IW'($urandom_range(0, NS - 1));
      s.luTag     = TW'($urandom_range(1, 6));
      s.fillEn    = ($urandom_range(0, 2) == 0);
      s.fillIndex = IW'($urandom_range(0, NS - 1));
      s.fillTag   = TW'($urandom_range(1, 6));
      s.invLineEn = ($urandom_range(0, 9) == 0);
      s.invIndex  = IW'($urandom_range(0, NS - 1));
      applyStimulus();
    end

    $display("== %0d vectors applied, %0d miscompares ==", nVectors, nMiscompares);
    $finish;
  end

endmodule

// File: doc/v810_tagstore.md
V810_TAGSTORE -- requirements
Module: v810_tagstore

Interface
REQ-001 SHALL provide parameter index_width, default 7, meaning log2 of the number of sets.
REQ-002 SHALL provide parameter tag_width, default 22, meaning the stored tag bits per way.
REQ-003 SHALL provide these ports (clock and reset first):
- clock  in  1  sole clock; all state changes on its rising edge.
- reset  in  1  synchronous, active-high reset.
- lu_index  in  index_width  lookup set.
- lu_tag  in  tag_width  lookup tag.
- lu_en  in  1  lookup is real; on a hit it updates LRU.
- lu_hit  out  1  combinational hit.
- lu_way  out  1  combinational way that hit.
- fill_en  in  1  install fill_tag in set fill_index.
- fill_index  in  index_width  fill set.
- fill_tag  in  tag_width  fill tag.
- fill_way  out  1  combinational victim way for fill_index.
- inv_line_en  in  1  invalidate both ways of inv_index.
- inv_index  in  index_width  invalidate set.
- inv_all  in  1  start a whole-array invalidate.
- busy  out  1  a sweep is in progress; writes are ignored.
REQ-004 SHALL use one clock; reset SHALL be synchronous and active-high.

Function
REQ-005 SHALL implement a 2-way set-associative store of 2^index_width sets, with per way a tag and a valid bit, and per set one LRU bit naming the least-recently-used way.
REQ-006 lu_hit SHALL be 1 when a valid way in set lu_index holds lu_tag, and SHALL be forced to 0 while busy=1.
REQ-007 lu_way SHALL name the matching way; if both ways match, it SHALL name way 0; when lu_hit=0 it SHALL be 0.
REQ-008 Reads SHALL be asynchronous: a write at edge N SHALL be visible to lookups in the cycle after edge N.
REQ-009 When lu_en=1, lu_hit=1 and busy=0 at an edge, the LRU bit of lu_index SHALL become the complement of lu_way.
REQ-010 fill_way SHALL be selected as follows:
- the way holding fill_tag validly, if any;
- else way 0 if it is invalid;
- else way 1 if it is invalid;
- else the way named by the LRU bit.
REQ-011 When fill_en=1 and busy=0 at an edge, the store SHALL write fill_tag with valid=1 into way fill_way of set fill_index, and set that set's LRU bit to the complement of fill_way.
REQ-012 When inv_line_en=1 and busy=0 at an edge, the store SHALL clear both valid bits of inv_index and clear its LRU bit to 0.
REQ-013 Same-edge priority SHALL be sweep/inv_all > inv_line > fill > lookup LRU update. A lower-priority operation that touches the same set as a higher-priority one SHALL be dropped; operations on different sets SHALL all take effect.
REQ-014 The FSM SHALL have two states, IDLE and SWEEP; busy SHALL be 1 exactly in SWEEP.
REQ-015 In IDLE, inv_all=1 SHALL move the FSM to SWEEP with the sweep counter at 0.
REQ-016 In SWEEP, each edge SHALL clear both valid bits and the LRU bit of set counter, then increment the counter.
REQ-017 At counter=2^index_width-1 the FSM SHALL clear that set and return to IDLE, so a sweep lasts exactly 2^index_width cycles.
REQ-018 inv_all=1 during SWEEP SHALL restart the counter at 0.
REQ-019 While busy=1, fill_en, inv_line_en and lu_en SHALL have no effect.
REQ-020 The sweep counter SHALL be index_width bits wide and SHALL never wrap past the last set while in SWEEP.

Reset
REQ-021 reset=1 at an edge SHALL enter SWEEP with counter 0, whatever the current state, including mid-sweep. busy SHALL read 1 from that edge and lu_hit SHALL read 0.
REQ-022 Tag arrays SHALL NOT be reset directly; only valid and LRU bits SHALL be cleared, and only by the sweep.
REQ-023 reset held high SHALL hold counter at 0. busy SHALL fall 2^index_width cycles after the edge on which reset was last sampled high.

Verification (index_width=2, tag_width=8)
REQ-024 Release reset -> busy=1 for exactly 4 cycles, then 0; a lookup of any index/tag then gives lu_hit=0.
REQ-025 Fill set 1 with tag 0x11, then tag 0x22 -> way0=0x11 and way1=0x22; lookup (1,0x22) gives hit with lu_way=1; lookup (1,0x33) gives no hit.
REQ-026 With set 1 full, apply lu_en on (1,0x11), then fill 0x33 -> fill_way=1; 0x22 is evicted; 0x11 and 0x33 both hit.
REQ-027 Fill (2,0x44) twice -> only way0 is written; way1 stays invalid; fill_way reads 1 for a subsequent new tag.
REQ-028 Apply inv_all, then inv_all again at sweep cycle 2, with fill_en held throughout -> busy lasts 6 cycles total, no fill lands, and all lookups miss afterwards.
REQ-029 On the same edge, apply inv_line_en on set 3 and fill_en on set 3 -> set 3 has no valid ways afterwards. Repeat with the fill on set 0 instead -> the fill lands in set 0.
